// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types and defaults for the Wishbone bus arbiter: state encoding
// and default sizing for master count and grant-hold timeout.
package wb_bus_arbiter_pkg;

  localparam int unsigned DEF_N_MASTERS      = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_bus_arbiter_picker.sv
// rr_priority_picker: combinational round-robin search for the first set
// request bit strictly after last_owner, wrapping modulo N_MASTERS.
module rr_priority_picker #(
  parameter int unsigned N_MASTERS     = 2,
  parameter int unsigned N_BITS_MASTER = 1
) (
  input  logic [N_MASTERS-1:0]     req,
  input  logic [N_BITS_MASTER-1:0] last_owner,
  output logic [N_BITS_MASTER-1:0] winner,
  output logic                     valid
);

  int unsigned idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned off = 1; off <= N_MASTERS; off++) begin
      idx = (32'(last_owner) + off) % N_MASTERS;
      if (!valid && req[idx[N_BITS_MASTER-1:0]]) begin
        valid  = 1'b1;
        winner = idx[N_BITS_MASTER-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone bus arbiter with CYC-framed grants and a one-cycle
// turnaround. Define WB_ARB_TIMEOUT_EN to revoke grants held too long.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS      = DEF_N_MASTERS,
  parameter int unsigned N_BITS_MASTER  = 1,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned N_BITS_TIMEOUT = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MASTERS-1:0]     cyc_i,
  output logic [N_MASTERS-1:0]     gnt_o,
  output logic [N_BITS_MASTER-1:0] owner_o,
  output logic                     bus_busy_o,
  output logic                     timeout_o,
  output logic [N_BITS_MASTER-1:0] timeout_id_o
);

  // Reject inconsistent sizing at elaboration rather than mis-arbitrating.
  if (N_MASTERS < 2 || (1 << N_BITS_MASTER) < N_MASTERS ||
      TIMEOUT_CYCLES < 2 || N_BITS_TIMEOUT < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_cfg
    $error("wb_bus_arbiter: inconsistent parameters");
  end

  arb_state_e               state;
  logic [N_BITS_MASTER-1:0] last_owner;
  logic [N_BITS_MASTER-1:0] pick_idx;
  logic                     pick_valid;

  rr_priority_picker #(
    .N_MASTERS     (N_MASTERS),
    .N_BITS_MASTER (N_BITS_MASTER)
  ) u_picker (
    .req        (cyc_i),
    .last_owner (last_owner),
    .winner     (pick_idx),
    .valid      (pick_valid)
  );

`ifdef WB_ARB_TIMEOUT_EN
  logic [N_BITS_TIMEOUT-1:0] hold_cnt;
`else
  assign timeout_o    = 1'b0;
  assign timeout_id_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      gnt_o      <= '0;
      owner_o    <= '0;
      bus_busy_o <= 1'b0;
      last_owner <= N_BITS_MASTER'(N_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      hold_cnt     <= '0;
      timeout_o    <= 1'b0;
      timeout_id_o <= '0;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      unique case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state      <= ARB_GRANT;
            gnt_o      <= N_MASTERS'(1) << pick_idx;
            owner_o    <= pick_idx;
            last_owner <= pick_idx;
            bus_busy_o <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            hold_cnt   <= '0;
`endif
          end
        end
        ARB_GRANT: begin
          // Dropping CYC always passes through IDLE, giving the dead cycle.
          if (!cyc_i[owner_o]) begin
            state      <= ARB_IDLE;
            gnt_o      <= '0;
            bus_busy_o <= 1'b0;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (hold_cnt == N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1)) begin
            state        <= ARB_ABORT;
            gnt_o        <= '0;
            bus_busy_o   <= 1'b0;
            timeout_o    <= 1'b1;
            timeout_id_o <= owner_o;
          end else if (hold_cnt != N_BITS_TIMEOUT'(TIMEOUT_CYCLES)) begin
            hold_cnt <= hold_cnt + N_BITS_TIMEOUT'(1);
          end
`endif
        end
        ARB_ABORT: state <= ARB_IDLE;
        default:   state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter (2 masters, timeout of 8 cycles when
// WB_ARB_TIMEOUT_EN is defined).
module tb_wb_bus_arbiter;

  localparam int N   = 2;
  localparam int NB  = 1;
  localparam int TO  = 8;
  localparam int NBT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  cyc;
  logic [N-1:0]  gnt;
  logic [NB-1:0] owner;
  logic          busy;
  logic          to;
  logic [NB-1:0] toid;

  always #5 clk = ~clk;

  wb_bus_arbiter #(
    .N_MASTERS      (N),
    .N_BITS_MASTER  (NB),
    .TIMEOUT_CYCLES (TO),
    .N_BITS_TIMEOUT (NBT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cyc_i        (cyc),
    .gnt_o        (gnt),
    .owner_o      (owner),
    .bus_busy_o   (busy),
    .timeout_o    (to),
    .timeout_id_o (toid)
  );

  typedef struct {
    logic [N-1:0]  gnt;
    logic          busy;
    logic [NB-1:0] owner;
    logic          to;
    logic [NB-1:0] toid;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: 0 idle, 1 grant, 2 abort.
  int           m_state, m_last, m_owner, m_hold, m_toid;
  logic [N-1:0] m_gnt;
  logic         m_busy, m_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] c, input logic r);
    if (r) begin
      m_state = 0; m_last = N - 1; m_owner = 0; m_hold = 0;
      m_gnt = '0; m_busy = 1'b0; m_to = 1'b0; m_toid = 0;
    end else begin
      m_to = 1'b0;
      case (m_state)
        0: begin
          for (int i = 1; i <= N; i++) begin
            int j;
            j = (m_last + i) % N;
            if (c[j]) begin
              m_state = 1; m_owner = j; m_last = j; m_hold = 0;
              m_gnt = '0; m_gnt[j] = 1'b1; m_busy = 1'b1;
              break;
            end
          end
        end
        1: begin
          if (!c[m_owner]) begin
            m_state = 0; m_gnt = '0; m_busy = 1'b0;
          end else begin
`ifdef WB_ARB_TIMEOUT_EN
            if (m_hold == TO - 1) begin
              m_state = 2; m_gnt = '0; m_busy = 1'b0; m_to = 1'b1; m_toid = m_owner;
            end else
`endif
            if (m_hold < TO) m_hold++;
          end
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic step(input logic [N-1:0] c, input logic r);
    exp_t e;
    cyc = c;
    rst = r;
    model_edge(c, r);
    e = '{m_gnt, m_busy, NB'(m_owner), m_to, NB'(m_toid)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("gnt", gnt, e.gnt);
    check("busy", busy, e.busy);
    if (e.busy) check("owner", owner, e.owner);
    check("timeout", to, e.to);
    if (e.to) check("timeout_id", toid, e.toid);
    check("onehot0", $onehot0(gnt), 1);
    check("busy_iff_gnt", gnt != '0, busy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rc;
    logic         rr;
    rst = 1'b1;
    cyc = '0;
    @(negedge clk);

    // Reset with both masters requesting; master 0 wins first.
    step(2'b11, 1'b1); check("rst_gnt", gnt, 2'b00); check("rst_busy", busy, 1'b0);
    step(2'b11, 1'b1); check("rst_gnt2", gnt, 2'b00);
    step(2'b11, 1'b0); check("first_gnt", gnt, 2'b01);

    // Contention: alternate owners with one dead cycle between them.
    repeat (3) step(2'b11, 1'b0);
    step(2'b10, 1'b0); check("turn0_idle", gnt, 2'b00);
    step(2'b11, 1'b0); check("turn0_m1", gnt, 2'b10);
    repeat (3) step(2'b11, 1'b0);
    step(2'b01, 1'b0); check("turn1_idle", gnt, 2'b00);
    step(2'b11, 1'b0); check("turn1_m0", gnt, 2'b01);
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);

    // Single requester, re-granted after each turnaround.
    repeat (2) begin
      step(2'b10, 1'b0); check("single_gnt", gnt, 2'b10); check("single_owner", owner, 1'b1);
      step(2'b10, 1'b0);
      step(2'b10, 1'b0);
      step(2'b00, 1'b0); check("single_rel", gnt, 2'b00);
    end

    // Late requester raises CYC as master 0 drops it.
    step(2'b01, 1'b0); check("late_m0", gnt, 2'b01);
    step(2'b01, 1'b0);
    step(2'b10, 1'b0); check("late_idle", gnt, 2'b00);
    step(2'b10, 1'b0); check("late_m1", gnt, 2'b10);
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);

    // Withdrawn request from master 1 while master 0 owns the bus.
    step(2'b01, 1'b0); check("wd_m0", gnt, 2'b01);
    step(2'b11, 1'b0);
    step(2'b01, 1'b0);
    step(2'b00, 1'b0); check("wd_idle", gnt, 2'b00);
    step(2'b00, 1'b0); check("wd_nogrant", gnt, 2'b00);

    // Reset mid-grant drops the grant on the next edge.
    step(2'b01, 1'b0);
    step(2'b01, 1'b1); check("rst_mid_gnt", gnt, 2'b00); check("rst_mid_busy", busy, 1'b0);
    step(2'b00, 1'b0);

    // Randomised traffic with occasional reset.
    rc = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rc = N'($urandom_range(0, 3));
      rr = ($urandom_range(0, 99) == 0);
      step(rc, rr);
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Timeout: master 0 holds CYC with master 1 waiting.
    begin
      int n01, n10, nto, first_id;
      n01 = 0; n10 = 0; nto = 0; first_id = -1;
      step(2'b00, 1'b1);
      step(2'b00, 1'b0);
      for (int i = 0; i < 20; i++) begin
        step(2'b11, 1'b0);
        if (gnt == 2'b01) n01++;
        if (gnt == 2'b10) n10++;
        if (to) begin
          nto++;
          if (first_id < 0) first_id = int'(toid);
        end
      end
      check("to_m0_cycles", n01, TO);
      check("to_m1_cycles", n10, TO);
      check("to_pulses", nto, 2);
      check("to_first_id", first_id, 0);
    end
`endif

    step(2'b00, 1'b0);
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
